// File: rtl/serial_to_parallel_rx.sv
// rtl/serial_to_parallel_rx.sv - bit-serial RX byte framer with COM-based link lock
// Optional build macro: SP_RX_SLIDE_ALIGN_EN (bit-phase search for COM while in SEARCH).
module serial_to_parallel_rx #(
    parameter logic [7:0]  COM_CHAR   = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_LOCKING = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_CNT  = 4'(LOCK_COUNT);
    localparam logic [4:0] LOCK_CMP  = 5'(LOCK_COUNT);

    state_t     state, state_next;
    logic [6:0] shift_reg;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic [3:0] com_cnt, com_cnt_next;
    logic [7:0] data_next;
    logic       valid_next;

    logic [7:0] window;
    logic       boundary;
    logic       is_com;
    logic [4:0] com_inc;

    assign window   = {shift_reg, data_in};
    assign boundary = (bit_cnt == 3'd7);
    assign is_com   = (window == COM_CHAR);
    assign com_inc  = {1'b0, com_cnt} + 5'd1;
    assign active   = (state == ST_ACTIVE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_SEARCH;
            shift_reg <= 7'd0;
            bit_cnt   <= 3'd0;
            com_cnt   <= 4'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= window[6:0];
            bit_cnt   <= bit_cnt_next;
            com_cnt   <= com_cnt_next;
            data_out  <= data_next;
            valid_out <= valid_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt + 3'd1;
        com_cnt_next = com_cnt;
        data_next    = data_out;
        valid_next   = valid_out;

        case (state)
            ST_SEARCH: begin
`ifdef SP_RX_SLIDE_ALIGN_EN
                // Any bit phase may start a lock; a match re-anchors the byte counter.
                if (is_com) begin
                    bit_cnt_next = 3'd0;
                    com_cnt_next = 4'd1;
                    if (LOCK_CNT == 4'd1) begin
                        state_next = ST_ACTIVE;
                        data_next  = COM_CHAR;
                    end else begin
                        state_next = ST_LOCKING;
                        data_next  = 8'h00;
                    end
                    valid_next = 1'b0;
                end else if (boundary) begin
                    data_next  = 8'h00;
                    valid_next = 1'b0;
                end
`else
                if (boundary) begin
                    data_next  = 8'h00;
                    valid_next = 1'b0;
                    if (is_com) begin
                        com_cnt_next = 4'd1;
                        if (LOCK_CNT == 4'd1) begin
                            state_next = ST_ACTIVE;
                            data_next  = COM_CHAR;
                        end else begin
                            state_next = ST_LOCKING;
                        end
                    end
                end
`endif
            end
            ST_LOCKING: begin
                if (boundary) begin
                    data_next  = 8'h00;
                    valid_next = 1'b0;
                    if (is_com) begin
                        if (com_inc >= LOCK_CMP) begin
                            com_cnt_next = LOCK_CNT;
                            state_next   = ST_ACTIVE;
                            data_next    = COM_CHAR;
                        end else begin
                            com_cnt_next = com_inc[3:0];
                        end
                    end else begin
                        com_cnt_next = 4'd0;
                        state_next   = ST_SEARCH;
                    end
                end
            end
            ST_ACTIVE: begin
                if (boundary) begin
                    if (is_com) begin
                        data_next  = COM_CHAR;
                        valid_next = 1'b0;
                    end else begin
                        data_next  = window;
                        valid_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next   = ST_SEARCH;
                com_cnt_next = 4'd0;
                data_next    = 8'h00;
                valid_next   = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/serial_to_parallel_rx.md
# serial_to_parallel_rx

Receive-side serial-to-parallel converter for the PHY RX path: shifts in one bit per clock, frames bytes, locks onto the link after a run of COM characters, and presents aligned bytes with a valid flag to the 1:2 demultiplexer directly downstream. Runs on the bit-rate clock; each output byte is held stable for one full byte period (8 clocks) so the downstream byte-clock stage samples it once.

## Interface
- COM_CHAR, 8'hBC, idle/alignment character
- LOCK_COUNT, 4, consecutive COM bytes required to enter ACTIVE (legal 1..15)

- clk  input  1  bit-rate clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset, 1 = run)
- data_in  input  1  serial bit, MSB first
- data_out  output  8  framed byte
- valid_out  output  1  data_out carries a payload byte
- active  output  1  link locked (LOCK_COUNT consecutive COM seen)

## Operation
- Reset (reset==0 at a rising edge): shift register=0, bit counter=0, COM counter=0, state=SEARCH, data_out=8'h00, valid_out=0, active=0.
- Shift register shifts left each clock; new byte = {sr[6:0], data_in}.
- Bit counter 3 bits, wraps 7->0; byte boundary when counter==7 (the 8th bit is being sampled).
- States (evaluated only at byte boundary unless noted):
  - SEARCH: byte==COM -> COM count=1, go LOCKING (or straight to ACTIVE if LOCK_COUNT==1); else stay.
  - LOCKING: byte==COM -> count+1; count reaches LOCK_COUNT -> ACTIVE; byte!=COM -> count=0, SEARCH.
  - ACTIVE: sticky until reset. byte!=COM -> data_out=byte, valid_out=1. byte==COM -> data_out=COM_CHAR, valid_out=0.
- active=1 exactly when state==ACTIVE.
- Outside ACTIVE: data_out=8'h00, valid_out=0 at every boundary.
- COM counter saturates at LOCK_COUNT; no overflow.

## Timing
- Byte whose MSB is sampled at edge k is on data_out/valid_out after edge k+7 and held through edge k+15.
- active rises after the boundary edge of the LOCK_COUNT-th consecutive COM byte; that byte itself is output as COM_CHAR with valid_out=0.
- First payload byte after lock: valid_out=1 after its own boundary edge (same 7-cycle latency).
- Reset mid-byte or mid-lock: all state cleared on that edge; counting restarts at the next edge with reset==1, that bit being bit 7 (MSB) of a new byte.
- data_in is ignored on edges where reset==0.

## Configuration
- SP_RX_SLIDE_ALIGN_EN defined: in SEARCH only, the window {sr[6:0], data_in} is compared with COM_CHAR on every clock; a match is treated as a byte boundary (bit counter forced to 0 next, COM count=1, go LOCKING). Locks to COM at any bit phase.
- Undefined: byte phase fixed by the counter from reset release; COM at a non-boundary offset never matches.
- LOCKING and ACTIVE behave identically in both builds.

## Test plan
- Reset held low 20 clocks with random data_in -> data_out=8'h00, valid_out=0, active=0 throughout.
- From reset release, 4 x 8'hBC then 8'h5A, 8'hC3 MSB first -> active=1 after edge 31; data_out=8'h5A valid_out=1 after edge 39, 8'hC3 after edge 47, each held 8 clocks.
- 3 x 8'hBC, 8'h11, 4 x 8'hBC, 8'h77 -> active stays 0 through 8'h11; rises after 8th byte; 8'h77 output valid.
- In ACTIVE: 8'hFF, 8'hBC, 8'h01 -> valid_out 1,0,1; data_out FF, BC, 01.
- Reset pulsed low for 1 clock mid-payload byte -> next edge outputs 00/0/0; relock needs 4 fresh COM bytes.
- 3 garbage bits then 4 x 8'hBC, 8'h42: with SP_RX_SLIDE_ALIGN_EN -> lock and 8'h42 valid; without -> active stays 0.
